tape_in: RTL and testbench
==========================

TAPE_IN -- requirements
Module: tape_in

Interface
REQ-001 Parameter FW, default 3, glitch-filter counter width (legal 1..6); FMAX = 2^FW-1.
REQ-002 Parameter TW, default 16, activity-timeout counter width (legal 2..20); TMAX = 2^TW-1.
REQ-003 clock  input  1  single system clock; all state SHALL be updated on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 ce  input  1  sample strobe; filter, timeout and period logic SHALL advance only when ce=1.
REQ-006 ear  input  1  raw asynchronous tape/EAR level.
REQ-007 tape  output  1  filtered tape level; feeds the audio mixer tape input.
REQ-008 edge  output  1  one-cycle pulse on any tape transition.
REQ-009 active  output  1  tape signal present (edges seen within the timeout).
REQ-010 period  output  16  ce strobes between the last two rising tape edges.
REQ-011 period_valid  output  1  one-cycle pulse when period is updated.

Function
REQ-012 ear SHALL pass through a two-flop synchronizer (s1, s2) clocked every cycle regardless of ce.
REQ-013 Filter counter cnt (FW bits): on ce, s2=1 and cnt<FMAX -> cnt+1; s2=0 and cnt>0 -> cnt-1; otherwise hold.
REQ-014 tape SHALL be set on the edge where next cnt==FMAX, cleared where next cnt==0, and held otherwise (hysteresis).
REQ-015 With ce held 1 and cnt at 0, a step on ear SHALL appear on tape after exactly 2+FMAX clocks; symmetric for a falling step from FMAX.
REQ-016 edge SHALL be 1 in exactly the cycle in which tape first shows a new value, 0 otherwise.
REQ-017 Timeout counter tcnt (TW bits): cleared on edge; else on ce incremented, saturating at TMAX.
REQ-018 active SHALL be set on edge and cleared on the clock where tcnt becomes TMAX.
REQ-019 Edge and timeout saturation in the same cycle: edge SHALL win (active=1, tcnt=0).
REQ-020 ce=0: cnt, tape, tcnt, period counter SHALL hold; edge and period_valid SHALL be 0.
REQ-021 Glitches shorter than FMAX ce strobes in mid-range cnt SHALL NOT change tape.

Reset
REQ-022 While reset=1: s1, s2, cnt, tape, edge, tcnt, active, period, period_valid, period counter and armed flag SHALL be 0.
REQ-023 Reset asserted mid-transition SHALL abort it; tape stays 0 and no edge or period_valid pulse is emitted on the reset cycle or the cycle after.

Configuration
REQ-024 Macro TAPE_PERIOD_EN defined: 16-bit period counter pcnt increments on ce (saturating 0xFFFF) and clears on each rising tape edge.
REQ-025 With TAPE_PERIOD_EN, on a rising tape edge while armed=1: period <= pcnt value before clear, period_valid=1 for that cycle; armed SHALL then be 1.
REQ-026 With TAPE_PERIOD_EN, the first rising edge after reset, or after active fell, SHALL only set armed (no period_valid); active falling SHALL clear armed.
REQ-027 Without TAPE_PERIOD_EN: ports present, period tied 0, period_valid tied 0, no period logic synthesized; all other behaviour identical.

Verification
REQ-028 FW=3, ce=1, ear 0->1 step after reset -> tape rises exactly 9 clocks later, edge=1 that cycle only, active=1.
REQ-029 FW=3, ce=1, tape=1 steady, ear low for 3 clocks then high -> tape stays 1, edge never asserted.
REQ-030 TW=4, ce=1, single edge then ear steady -> active falls exactly 15 clocks after edge cycle.
REQ-031 TAPE_PERIOD_EN, ce=1, FW=3, square wave on ear period 40 clocks -> first rising edge no pulse; every following rising edge period=40, period_valid one cycle.
REQ-032 ce pulsed every 4th clock, ear step -> tape rises after 2 clocks plus 7 ce strobes; period counts strobes not clocks (wave of 160 clocks -> period=40).
REQ-033 reset asserted while cnt=4 rising -> all outputs 0 next cycle; after release with ear=1, tape rises 9 clocks later, no period_valid on first edge.

Source files
------------

// File: rtl/tape_in.sv
// Tape/EAR input conditioner: synchronizer, hysteresis glitch filter, activity timeout.
// Define TAPE_PERIOD_EN to add the rising-edge period measurement (period/period_valid).
module tape_in #(
  parameter int FW = 3,
  parameter int TW = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ce,
  input  logic        ear,
  output logic        tape,
  output logic        tape_edge,
  output logic        active,
  output logic [15:0] period,
  output logic        period_valid
);

  localparam logic [FW-1:0] FMAX = '1;
  localparam logic [TW-1:0] TMAX = '1;

  logic          s1_q, s1_d, s2_q, s2_d;
  logic [FW-1:0] cnt_q, cnt_d;
  logic          tape_q, tape_d;
  logic          edge_q, edge_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          active_q, active_d;

  always_comb begin
    s1_d     = ear;
    s2_d     = s1_q;
    cnt_d    = cnt_q;
    tape_d   = tape_q;
    tcnt_d   = tcnt_q;
    active_d = active_q;
    if (ce) begin
      if (s2_q && cnt_q != FMAX)
        cnt_d = cnt_q + 1'b1;
      else if (!s2_q && cnt_q != '0)
        cnt_d = cnt_q - 1'b1;
      // Hysteresis: tape only moves at the counter rails.
      if (cnt_d == FMAX)
        tape_d = 1'b1;
      else if (cnt_d == '0)
        tape_d = 1'b0;
    end
    edge_d = tape_d ^ tape_q;
    if (edge_d)
      tcnt_d = '0;
    else if (ce && tcnt_q != TMAX)
      tcnt_d = tcnt_q + 1'b1;
    if (edge_d)
      active_d = 1'b1;
    else if (tcnt_d == TMAX)
      active_d = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      cnt_q    <= '0;
      tape_q   <= 1'b0;
      edge_q   <= 1'b0;
      tcnt_q   <= '0;
      active_q <= 1'b0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      cnt_q    <= cnt_d;
      tape_q   <= tape_d;
      edge_q   <= edge_d;
      tcnt_q   <= tcnt_d;
      active_q <= active_d;
    end
  end

  assign tape      = tape_q;
  assign tape_edge = edge_q;
  assign active    = active_q;

`ifdef TAPE_PERIOD_EN
  logic [15:0] pcnt_q, pcnt_d, pcnt_inc;
  logic [15:0] period_q, period_d;
  logic        pv_q, pv_d;
  logic        armed_q, armed_d;
  logic        rise;

  // pcnt_inc includes the strobe of the current cycle, so a rising edge
  // reports the full number of strobes since the previous rising edge.
  always_comb begin
    rise     = tape_d & ~tape_q;
    pcnt_inc = (pcnt_q == 16'hFFFF) ? pcnt_q : pcnt_q + 16'd1;
    pcnt_d   = pcnt_q;
    period_d = period_q;
    pv_d     = 1'b0;
    armed_d  = armed_q;
    if (ce)
      pcnt_d = pcnt_inc;
    if (rise) begin
      pcnt_d = '0;
      if (armed_q) begin
        period_d = pcnt_inc;
        pv_d     = 1'b1;
      end
      armed_d = 1'b1;
    end else if (active_q && !active_d) begin
      armed_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pcnt_q   <= '0;
      period_q <= '0;
      pv_q     <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      pcnt_q   <= pcnt_d;
      period_q <= period_d;
      pv_q     <= pv_d;
      armed_q  <= armed_d;
    end
  end

  assign period       = period_q;
  assign period_valid = pv_q;
`else
  assign period       = 16'd0;
  assign period_valid = 1'b0;
`endif

endmodule

// File: tb/tb_tape_in.sv
// Directed bench for tape_in: filter latency, glitch rejection, timeout, period, reset abort.
module tb_tape_in;

`ifdef TAPE_PERIOD_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ce    = 1'b1;
  logic        ear   = 1'b0;
  logic        tape, tape_edge, active, period_valid;
  logic [15:0] period;
  logic        tape4, edge4, active4, pv4;
  logic [15:0] period4;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clock = ~clock;

  tape_in #(.FW(3), .TW(16)) dut (
    .clock(clock), .reset(reset), .ce(ce), .ear(ear),
    .tape(tape), .tape_edge(tape_edge), .active(active),
    .period(period), .period_valid(period_valid)
  );

  tape_in #(.FW(3), .TW(4)) dut4 (
    .clock(clock), .reset(reset), .ce(ce), .ear(ear),
    .tape(tape4), .tape_edge(edge4), .active(active4),
    .period(period4), .period_valid(pv4)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ear   = 1'b0;
    ce    = 1'b1;
    tick(2);
    check_eq("rst_tape",   32'(tape), 0);
    check_eq("rst_edge",   32'(tape_edge), 0);
    check_eq("rst_active", 32'(active), 0);
    check_eq("rst_period", 32'(period), 0);
    check_eq("rst_pv",     32'(period_valid), 0);
    check_eq("rst4_tape",  32'(tape4 | edge4 | active4 | pv4), 0);
    check_eq("rst4_period", 32'(period4), 0);
    reset = 1'b0;
  endtask

  task automatic run_wave(input int half, input int div, input int n,
                          input int first, input int exp_rises);
    int  rises;
    bit  exp_rise, exp_pv;
    rises = 0;
    do_reset();
    for (int i = 0; i < n; i++) begin
      exp_rise = (i >= first) && (((i - first) % (2 * half)) == 0);
      exp_pv   = PEN && exp_rise && (i != first);
      check_eq("wave_rise", 32'(tape_edge & tape), 32'(exp_rise));
      check_eq("wave_pv",   32'(period_valid), 32'(exp_pv));
      if (exp_pv)
        check_eq("wave_period", 32'(period), 40);
      if (tape_edge && tape)
        rises++;
      ce  = ((i % div) == 0);
      ear = (((i / half) % 2) == 0);
      @(posedge clock);
      #1;
    end
    ce = 1'b1;
    check_eq("wave_rises", 32'(rises), 32'(exp_rises));
  endtask

  initial begin
    do_reset();
    tick(3);

    // Rising step: 2 synchronizer clocks + 7 filter clocks.
    ear = 1'b1;
    tick(8);
    check_eq("step_tape_early", 32'(tape), 0);
    check_eq("step_edge_early", 32'(tape_edge), 0);
    tick(1);
    check_eq("step_tape",   32'(tape), 1);
    check_eq("step_edge",   32'(tape_edge), 1);
    check_eq("step_active", 32'(active), 1);
    check_eq("step4_edge",  32'(tape4 & edge4), 1);
    tick(1);
    check_eq("step_edge_off", 32'(tape_edge), 0);
    check_eq("step_tape_hold", 32'(tape), 1);

    // TW=4 instance: active drops 15 clocks after its edge cycle.
    tick(13);
    check_eq("tmo_before", 32'(active4), 1);
    tick(1);
    check_eq("tmo_fall",   32'(active4), 0);
    check_eq("tmo_tw16",   32'(active), 1);

    // Three-clock low glitch with tape high is absorbed.
    ear = 1'b0;
    tick(3);
    ear = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick(1);
      check_eq("glitch_tape", 32'(tape), 1);
      check_eq("glitch_edge", 32'(tape_edge), 0);
    end

    // Falling step is symmetric.
    ear = 1'b0;
    tick(8);
    check_eq("fall_tape_early", 32'(tape), 1);
    tick(1);
    check_eq("fall_tape", 32'(tape), 0);
    check_eq("fall_edge", 32'(tape_edge), 1);

    // ce low freezes the filter.
    ear = 1'b1;
    ce  = 1'b0;
    tick(20);
    check_eq("ce0_tape", 32'(tape), 0);
    check_eq("ce0_edge", 32'(tape_edge), 0);
    ce = 1'b1;
    tick(6);
    check_eq("ce1_tape_early", 32'(tape), 0);
    tick(1);
    check_eq("ce1_tape", 32'(tape), 1);
    check_eq("ce1_edge", 32'(tape_edge), 1);

    run_wave(20, 1, 180, 9, 5);
    run_wave(80, 4, 400, 29, 3);

    // Reset in the middle of a rising transition (cnt=4).
    do_reset();
    ear = 1'b1;
    tick(6);
    reset = 1'b1;
    tick(1);
    check_eq("mid_rst_tape",   32'(tape), 0);
    check_eq("mid_rst_edge",   32'(tape_edge), 0);
    check_eq("mid_rst_active", 32'(active), 0);
    check_eq("mid_rst_pv",     32'(period_valid), 0);
    check_eq("mid_rst_period", 32'(period), 0);
    reset = 1'b0;
    tick(1);
    check_eq("post_rst_tape", 32'(tape), 0);
    check_eq("post_rst_edge", 32'(tape_edge), 0);
    check_eq("post_rst_pv",   32'(period_valid), 0);
    tick(7);
    check_eq("rerise_early", 32'(tape), 0);
    tick(1);
    check_eq("rerise_tape", 32'(tape), 1);
    check_eq("rerise_edge", 32'(tape_edge), 1);
    check_eq("rerise_pv",   32'(period_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
